// File: rtl/cpu_types_pkg.sv
// Core-wide scalar types shared by every pipeline stage.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

endpackage

// File: rtl/diaosi_types_pkg.sv
// Control enums for the fetch stage: redirect select and fetch FSM states.
package diaosi_types_pkg;

    typedef enum logic [1:0] {
        PC_NEXT = 2'd0,
        PC_BR   = 2'd1,
        PC_JUMP = 2'd2,
        PC_JR   = 2'd3
    } PCSrc_t;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        REDIR_PEND = 2'd1,
        HALTED     = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage boundary: hazard controls, redirects, icache port and IF/ID contents.
interface fetch_stage_if;
    import cpu_types_pkg::*;
    import diaosi_types_pkg::*;

    logic   pc_en;
    logic   id_en;
    logic   flushed;
    PCSrc_t pc_src;
    word_t  br_target;
    word_t  jmp_target;
    word_t  jr_target;
    logic   halt;
    logic   ihit;
    word_t  iload;
    logic   imemREN;
    word_t  imemaddr;
    word_t  ifid_instr;
    word_t  ifid_npc;
    logic   ifid_valid;

    modport fs (
        input  pc_en, id_en, flushed, pc_src, br_target, jmp_target, jr_target,
        input  halt, ihit, iload,
        output imemREN, imemaddr, ifid_instr, ifid_npc, ifid_valid
    );

    modport tb (
        output pc_en, id_en, flushed, pc_src, br_target, jmp_target, jr_target,
        output halt, ihit, iload,
        input  imemREN, imemaddr, ifid_instr, ifid_npc, ifid_valid
    );

endinterface

// File: rtl/fetch_stage_pc.sv
// Program counter and fetch FSM: sequential advance, redirects held across
// icache misses, and a sticky halt that only reset clears.
module fetch_stage_pc
    import cpu_types_pkg::*;
    import diaosi_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         pc_en,
    input  logic         halt,
    input  logic         ihit,
    input  PCSrc_t       pc_src,
    input  word_t        br_target,
    input  word_t        jmp_target,
    input  word_t        jr_target,
    output word_t        pc,
    output fetch_state_t state,
    output logic         imem_ren
);

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        pend_q, pend_d;
    logic         imem_ren_q, imem_ren_d;
    word_t        target;
    logic         redirect;

    always_comb begin
        redirect = (pc_src != PC_NEXT);
        unique case (pc_src)
            PC_BR:   target = br_target;
            PC_JUMP: target = jmp_target;
            PC_JR:   target = jr_target;
            default: target = pc_q;
        endcase
    end

    // Halt outranks redirects and advance; a miss parks the redirect in pend.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        case (state_q)
            RUN: begin
                if (halt) begin
                    state_d = HALTED;
                end else if (redirect) begin
                    if (ihit) begin
                        pc_d = target;
                    end else begin
                        pend_d  = target;
                        state_d = REDIR_PEND;
                    end
                end else if (pc_en && ihit) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            REDIR_PEND: begin
                if (halt) begin
                    state_d = HALTED;
                end else if (ihit) begin
                    pc_d    = redirect ? target : pend_q;
                    state_d = RUN;
                end else if (redirect) begin
                    pend_d = target;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        imem_ren_d = (state_d != HALTED);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= RUN;
            pc_q       <= PC_INIT;
            pend_q     <= 32'h0;
            imem_ren_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            imem_ren_q <= imem_ren_d;
        end
    end

    assign pc       = pc_q;
    assign state    = state_q;
    assign imem_ren = imem_ren_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC/FSM sub-block plus the IF/ID pipeline latch.
module fetch_stage
    import cpu_types_pkg::*;
    import diaosi_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input logic        CLK,
    input logic        RST,
    fetch_stage_if.fs  bus
);

    word_t        pc;
    fetch_state_t state;
    logic         imem_ren;

    word_t ifid_instr_q, ifid_instr_d;
    word_t ifid_npc_q, ifid_npc_d;
    logic  ifid_valid_q, ifid_valid_d;

    fetch_stage_pc #(.PC_INIT(PC_INIT)) u_pc (
        .CLK        (CLK),
        .RST        (RST),
        .pc_en      (bus.pc_en),
        .halt       (bus.halt),
        .ihit       (bus.ihit),
        .pc_src     (bus.pc_src),
        .br_target  (bus.br_target),
        .jmp_target (bus.jmp_target),
        .jr_target  (bus.jr_target),
        .pc         (pc),
        .state      (state),
        .imem_ren   (imem_ren)
    );

    // Only a clean hit in RUN with no redirect delivers a real instruction.
    always_comb begin
        ifid_instr_d = ifid_instr_q;
        ifid_npc_d   = ifid_npc_q;
        ifid_valid_d = ifid_valid_q;
        if (bus.flushed) begin
            ifid_instr_d = 32'h0;
            ifid_npc_d   = 32'h0;
            ifid_valid_d = 1'b0;
        end else if (bus.id_en) begin
            if ((state == RUN) && bus.ihit && (bus.pc_src == PC_NEXT)) begin
                ifid_instr_d = bus.iload;
                ifid_npc_d   = pc + 32'd4;
                ifid_valid_d = 1'b1;
            end else begin
                ifid_instr_d = 32'h0;
                ifid_npc_d   = 32'h0;
                ifid_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ifid_instr_q <= 32'h0;
            ifid_npc_q   <= 32'h0;
            ifid_valid_q <= 1'b0;
        end else begin
            ifid_instr_q <= ifid_instr_d;
            ifid_npc_q   <= ifid_npc_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign bus.imemaddr   = pc;
    assign bus.imemREN    = imem_ren;
    assign bus.ifid_instr = ifid_instr_q;
    assign bus.ifid_npc   = ifid_npc_q;
    assign bus.ifid_valid = ifid_valid_q;

endmodule
